layer_stream_driver: RTL and testbench
======================================

LAYER_STREAM_DRIVER -- requirements
Module: layer_stream_driver

Interface
REQ-001 Parameter N, default 6: elements per input vector sent to the layer.
REQ-002 Parameter M, default 8: elements per output vector received from the layer.
REQ-003 Parameter T, default 16: signed data width in bits.
REQ-004 Parameter LOGN, default 3: index width for the input buffer; 2^LOGN SHALL be at least N.
REQ-005 Parameter LOGM, default 3: index width for the result buffer; 2^LOGM SHALL be at least M.
REQ-006 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-007 reset  input  1  asynchronous, active-high reset.
REQ-008 start  input  1  request to begin one transaction (send vector, collect result).
REQ-009 ld_en  input  1  write enable for the input vector buffer.
REQ-010 ld_addr  input  LOGN  write index for the input vector buffer.
REQ-011 ld_data  input  T  signed element written into the input vector buffer.
REQ-012 tx_valid  output  1  element valid toward the layer's s_valid.
REQ-013 tx_ready  input  1  layer's s_ready.
REQ-014 tx_data  output  T  signed element toward the layer's data_in.
REQ-015 rx_valid  input  1  layer's m_valid.
REQ-016 rx_ready  output  1  toward the layer's m_ready.
REQ-017 rx_data  input  T  layer's data_out.
REQ-018 rx_stall  input  1  when high, forces rx_ready low (backpressure injection).
REQ-019 rd_addr  input  LOGM  result buffer read index.
REQ-020 rd_data  output  T  registered result buffer read data.
REQ-021 busy  output  1  high in every state except IDLE.
REQ-022 done  output  1  one-cycle pulse when a transaction completes.

Function
REQ-023 The FSM SHALL have four states: IDLE, SEND, RECV and FIN.
REQ-024 IDLE->SEND SHALL occur on the cycle after start=1 is sampled; start outside IDLE SHALL be ignored.
REQ-025 ld_en SHALL write ld_data to xbuf[ld_addr] only in IDLE; ld_en while busy SHALL be ignored; ld_addr>=N SHALL be ignored.
REQ-026 In SEND, tx_valid SHALL be 1 and tx_data SHALL equal xbuf[tx_idx]; tx_idx SHALL be 0 on SEND entry.
REQ-027 A transfer SHALL occur on a cycle with tx_valid=1 and tx_ready=1, and SHALL increment tx_idx.
REQ-028 While tx_valid=1 and tx_ready=0, tx_data and tx_idx SHALL hold stable.
REQ-029 The transfer of element N-1 SHALL move the FSM to RECV on the next cycle, with tx_valid=0 in RECV.
REQ-030 In RECV, rx_ready SHALL equal NOT rx_stall; in all other states rx_ready SHALL be 0.
REQ-031 In RECV, a cycle with rx_valid=1 and rx_ready=1 SHALL write rx_data to ybuf[rx_idx] and increment rx_idx; rx_idx SHALL be 0 on RECV entry.
REQ-032 Acceptance of element M-1 SHALL move the FSM to FIN.
REQ-033 FIN SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-034 rx_valid outside RECV SHALL be ignored and SHALL NOT write ybuf.
REQ-035 rd_data SHALL equal ybuf[rd_addr] one cycle after rd_addr is presented, in any state.
REQ-036 A read and a write to the same ybuf index in the same cycle SHALL return the old value.
REQ-037 Data SHALL pass through unmodified: no arithmetic, saturation or sign change.
REQ-038 xbuf contents SHALL persist across transactions, so start with no new loads resends the previous vector.
REQ-039 Minimum latency from start to done SHALL be N+M+2 cycles when tx_ready and rx_valid are held high.

Reset
REQ-040 reset=1 SHALL immediately (asynchronously) force IDLE, tx_idx=0, rx_idx=0, tx_valid=0, rx_ready=0, busy=0, done=0, rd_data=0 and tx_data=0.
REQ-041 Reset SHALL NOT clear xbuf or ybuf.
REQ-042 Reset asserted mid-SEND or mid-RECV SHALL abort the transaction without a done pulse.
REQ-043 After reset deasserts, the next start SHALL begin a clean transaction from tx_idx=0.

Verification
REQ-044 Load xbuf = {1,-2,3,-4,5,-6}, start, tx_ready=1, rx_valid=1 with rx_data = 100..107 -> tx_data sequence 1,-2,3,-4,5,-6; done at cycle N+M+2=16 after start; rd_addr 0..7 returns 100..107.
REQ-045 Toggle tx_ready 1,0,0,1 during SEND -> tx_data holds on stalled cycles; no element is duplicated or skipped.
REQ-046 Hold rx_stall=1 for 5 cycles mid-RECV with rx_valid=1 -> rx_ready=0 and no ybuf write during the stall; values resume in order.
REQ-047 Pulse start and ld_en during RECV -> no new transaction starts, xbuf is unchanged, and exactly one done pulse occurs.
REQ-048 Assert reset after 3 transfers in SEND -> tx_valid=0 and busy=0 immediately with no done; a following start resends from element 0.
REQ-049 Integrate with layer_8_6_1_16 (tx to s_*, rx to m_*) -> 8 results captured and done asserted once.

Source files
------------

// File: rtl/layer_stream_driver.sv
// Streams a locally buffered input vector into a valid/ready layer, then
// collects the layer's output vector into a readable result buffer.
module layer_stream_driver #(
    parameter int unsigned N    = 6,
    parameter int unsigned M    = 8,
    parameter int unsigned T    = 16,
    parameter int unsigned LOGN = 3,
    parameter int unsigned LOGM = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                ld_en,
    input  logic [LOGN-1:0]     ld_addr,
    input  logic signed [T-1:0] ld_data,
    output logic                tx_valid,
    input  logic                tx_ready,
    output logic signed [T-1:0] tx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    input  logic signed [T-1:0] rx_data,
    input  logic                rx_stall,
    input  logic [LOGM-1:0]     rd_addr,
    output logic signed [T-1:0] rd_data,
    output logic                busy,
    output logic                done
);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_RECV, S_FIN} state_t;

    localparam logic [LOGN-1:0] TX_LAST = LOGN'(N - 1);
    localparam logic [LOGM-1:0] RX_LAST = LOGM'(M - 1);

    state_t              state_q, state_d;
    logic [LOGN-1:0]     tx_idx_q, tx_idx_d;
    logic [LOGM-1:0]     rx_idx_q, rx_idx_d;
    logic signed [T-1:0] rd_data_q;
    logic signed [T-1:0] xbuf_q [2**LOGN];
    logic signed [T-1:0] ybuf_q [2**LOGM];

    logic tx_fire, rx_fire, ld_fire;

    assign tx_valid = (state_q == S_SEND);
    assign tx_data  = tx_valid ? xbuf_q[tx_idx_q] : '0;
    assign rx_ready = (state_q == S_RECV) && !rx_stall;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_FIN);
    assign rd_data  = rd_data_q;

    assign tx_fire = tx_valid && tx_ready;
    assign rx_fire = rx_ready && rx_valid;
    assign ld_fire = (state_q == S_IDLE) && ld_en && (32'(ld_addr) < N);

    always_comb begin
        state_d  = state_q;
        tx_idx_d = tx_idx_q;
        rx_idx_d = rx_idx_q;
        case (state_q)
            S_IDLE: if (start) begin
                state_d  = S_SEND;
                tx_idx_d = '0;
            end
            S_SEND: if (tx_fire) begin
                if (tx_idx_q == TX_LAST) begin
                    state_d  = S_RECV;
                    tx_idx_d = '0;
                    rx_idx_d = '0;
                end else begin
                    tx_idx_d = tx_idx_q + 1'b1;
                end
            end
            S_RECV: if (rx_fire) begin
                if (rx_idx_q == RX_LAST) begin
                    state_d  = S_FIN;
                    rx_idx_d = '0;
                end else begin
                    rx_idx_d = rx_idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tx_idx_q  <= '0;
            rx_idx_q  <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tx_idx_q  <= tx_idx_d;
            rx_idx_q  <= rx_idx_d;
            rd_data_q <= ybuf_q[rd_addr];
        end
    end

    // Buffers are deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_fire) xbuf_q[ld_addr] <= ld_data;
        if (rx_fire) ybuf_q[rx_idx_q] <= rx_data;
    end

endmodule

// File: tb/tb_layer_stream_driver.sv
// Directed + randomized bench for layer_stream_driver with a count-based stream model.
module tb_layer_stream_driver;
    localparam int N = 6, M = 8, T = 16, LOGN = 3, LOGM = 3;

    logic clk = 1'b0;
    logic reset, start, ld_en, tx_valid, tx_ready, rx_valid, rx_ready, rx_stall, busy, done;
    logic [LOGN-1:0] ld_addr;
    logic [LOGM-1:0] rd_addr;
    logic signed [T-1:0] ld_data, tx_data, rx_data, rd_data;

    layer_stream_driver #(.N(N), .M(M), .T(T), .LOGN(LOGN), .LOGM(LOGM)) dut (
        .clk(clk), .reset(reset), .start(start), .ld_en(ld_en), .ld_addr(ld_addr),
        .ld_data(ld_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_data(rx_data), .rx_stall(rx_stall),
        .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_assert = 0, n_fail = 0;
    logic signed [T-1:0] xexp [N];
    logic signed [T-1:0] ymod [M];
    bit ymod_ok = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int a, input logic signed [T-1:0] d);
        ld_en   = 1'b1;
        ld_addr = LOGN'(a);
        ld_data = d;
        tick();
        ld_en = 1'b0;
        if (a < N) xexp[a] = d;
    endtask

    task automatic readback();
        for (int a = 0; a < M; a++) begin
            rd_addr = LOGM'(a);
            tick();
            check("readback", 32'(rd_data), 32'(ymod[a]));
        end
    endtask

    // rmode: 0 always ready/valid, 1 tx_ready 1,0,0,1 pattern, 2 random
    // smode: 0 no stall, 1 one 5-cycle stall at element 3, 2 random stall
    task automatic txn(input int rmode, input int smode, input bit poke, output int lat);
        int txc = 0, rxc = 0, cyc = 0, stall_left = 0, pat_i = 0;
        int pat [4] = '{1, 0, 0, 1};
        bit stall_used = 1'b0, done_seen = 1'b0, rd_exp_ok = 1'b0;
        bit exp_txv, exp_rxr, exp_done;
        logic signed [T-1:0] rxq [M];
        logic signed [T-1:0] rd_exp;
        for (int i = 0; i < M; i++)
            rxq[i] = (rmode == 0 && smode == 0) ? T'(100 + i) : T'($urandom);
        lat = -1;
        start = 1'b1;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'(0));
        tick();
        start = 1'b0;
        while (!done_seen && cyc < 400) begin
            if (rmode == 0) tx_ready = 1'b1;
            else if (rmode == 1) tx_ready = (pat[pat_i % 4] != 0);
            else tx_ready = 1'($urandom_range(0, 1));
            if (txc < N) pat_i++;
            rx_valid = (rmode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            rx_data  = (txc == N && rxc < M) ? rxq[rxc] : T'($urandom);
            if (smode == 1) begin
                if (txc == N && rxc == 3 && !stall_used) begin
                    stall_left = 5;
                    stall_used = 1'b1;
                end
                rx_stall = (stall_left > 0);
                if (stall_left > 0) begin
                    rx_valid = 1'b1;
                    stall_left--;
                end
            end else if (smode == 2) rx_stall = ($urandom_range(0, 3) == 0);
            else rx_stall = 1'b0;
            if (poke && txc == N && rxc < M) begin
                start   = 1'b1;
                ld_en   = 1'b1;
                ld_addr = LOGN'($urandom_range(0, N - 1));
                ld_data = T'($urandom);
            end else begin
                start = 1'b0;
                ld_en = 1'b0;
            end
            rd_addr = LOGM'(rxc);
            @(negedge clk);
            if (rd_exp_ok) check("rd_old_value", 32'(rd_data), 32'(rd_exp));
            exp_txv  = (txc < N);
            exp_rxr  = (txc == N) && (rxc < M) && !rx_stall;
            exp_done = (rxc == M);
            check("tx_valid", 32'(tx_valid), 32'(exp_txv));
            if (exp_txv) check("tx_data", 32'(tx_data), 32'(xexp[txc]));
            check("rx_ready", 32'(rx_ready), 32'(exp_rxr));
            check("done", 32'(done), 32'(exp_done));
            check("busy", 32'(busy), 32'(1));
            if (exp_done) begin
                done_seen = 1'b1;
                lat = cyc + 2;
            end
            rd_exp    = ymod[rd_addr];
            rd_exp_ok = ymod_ok;
            if (exp_txv && tx_ready) txc++;
            if (exp_rxr && rx_valid) begin
                ymod[rxc] = rx_data;
                rxc++;
            end
            tick();
            cyc++;
        end
        if (!done_seen) check("txn_timeout", 32'(0), 32'(1));
        start = 1'b0; ld_en = 1'b0; rx_valid = 1'b0; rx_stall = 1'b0; tx_ready = 1'b0;
        @(negedge clk);
        check("done_pulse_end", 32'(done), 32'(0));
        check("busy_after", 32'(busy), 32'(0));
        ymod_ok = 1'b1;
        tick();
    endtask

    initial begin
        int lat;
        logic signed [T-1:0] v0 [8];
        v0 = '{16'sd1, -16'sd2, 16'sd3, -16'sd4, 16'sd5, -16'sd6, 16'sd77, 16'sd88};
        reset = 1'b1; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; rx_stall = 1'b0; rd_addr = '0;
        #1;
        check("rst_tx_valid", 32'(tx_valid), 32'(0));
        check("rst_rx_ready", 32'(rx_ready), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_done", 32'(done), 32'(0));
        check("rst_tx_data", 32'(tx_data), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
        #20;
        @(posedge clk); #1;
        reset = 1'b0;

        for (int a = 0; a < 8; a++) load(a, v0[a]);
        txn(0, 0, 1'b0, lat);
        check("latency", 32'(lat), 32'(N + M + 2));
        readback();
        for (int a = 0; a < M; a++) check("result_100", 32'(ymod[a]), 32'(100 + a));

        txn(1, 0, 1'b0, lat);   // resend same vector with tx backpressure
        readback();
        txn(0, 1, 1'b0, lat);   // rx stall window
        readback();
        txn(2, 0, 1'b1, lat);   // start/ld_en pokes during RECV must be ignored
        txn(0, 0, 1'b0, lat);
        readback();

        // reset mid-SEND after 3 transfers
        start = 1'b1; tick(); start = 1'b0;
        tx_ready = 1'b1;
        repeat (3) tick();
        check("mid_send_data", 32'(tx_data), 32'(xexp[3]));
        #2 reset = 1'b1;
        #1;
        check("abort_tx_valid", 32'(tx_valid), 32'(0));
        check("abort_busy", 32'(busy), 32'(0));
        check("abort_done", 32'(done), 32'(0));
        check("abort_tx_data", 32'(tx_data), 32'(0));
        tx_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("post_rst_done", 32'(done), 32'(0));
            check("post_rst_busy", 32'(busy), 32'(0));
        end
        tick();
        readback();
        txn(0, 0, 1'b0, lat);
        check("latency_after_rst", 32'(lat), 32'(N + M + 2));

        repeat (20) begin
            for (int a = 0; a < N; a++) load(a, T'($urandom));
            txn(2, 2, 1'($urandom_range(0, 1)), lat);
            readback();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
